// File: rtl/program_loader_if.sv
// program_loader_if: byte-stream input and instruction-memory write port of the
// program loader. The slave modport is the loader's side, master the host/memory side.
interface program_loader_if;
  logic [7:0]  byteIn;
  logic        byteValid;
  logic        byteReady;
  logic        imemWrEn;
  logic [31:0] imemAddr;
  logic [31:0] imemData;

  modport master (
    output byteIn, byteValid,
    input  byteReady, imemWrEn, imemAddr, imemData
  );

  modport slave (
    input  byteIn, byteValid,
    output byteReady, imemWrEn, imemAddr, imemData
  );
endinterface

// File: rtl/program_loader.sv
// program_loader: boot/launch controller. Streams a program in as bytes, packs them
// big-endian into 32-bit words, writes them to instruction memory, keeps the core PC
// pinned to startAddress while loading, then releases the core and waits for
// endProgram or a run timeout. Every output is registered.
// Optional checksum trailer: define PROGRAM_LOADER_CHECKSUM_EN.
module program_loader #(
  parameter int unsigned RUN_TIMEOUT   = 1000000,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [31:0]     loadBase,
  input  logic [15:0]     wordCount,
  program_loader_if.slave bus,
  output logic            pcSelect,
  output logic [31:0]     startAddress,
  input  logic            endProgram,
  output logic            busy,
  output logic            done,
  output logic            error
);

  typedef enum logic [2:0] {IDLE, LOAD, LAUNCH, RUN, DONE} state_t;

  state_t      state, stateNext;
  logic [15:0] total, totalNext;
  logic [15:0] wordIdx, wordIdxNext;
  logic [1:0]  byteCnt, byteCntNext;
  logic [23:0] shift, shiftNext;
  logic        allBytes, allBytesNext;
  logic [31:0] timer, timerNext;
  logic [31:0] baseNext;
  logic        byteReadyNext, imemWrEnNext;
  logic [31:0] imemAddrNext, imemDataNext;
  logic        pcSelectNext, busyNext, doneNext, errorNext;
  logic        accept;
  logic [31:0] word;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [31:0] sum, sumNext;
`endif

  assign accept = bus.byteValid && bus.byteReady;
  assign word   = {shift, bus.byteIn};

  // Next-state and next-output logic; all registers hold unless a state acts on them
  always_comb begin
    stateNext    = state;
    totalNext    = total;
    wordIdxNext  = wordIdx;
    byteCntNext  = byteCnt;
    shiftNext    = shift;
    allBytesNext = allBytes;
    timerNext    = timer;
    baseNext     = startAddress;
    imemWrEnNext = 1'b0;
    imemAddrNext = bus.imemAddr;
    imemDataNext = bus.imemData;
    errorNext    = error;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    sumNext      = sum;
`endif
    case (state)
      IDLE, DONE: begin
        if (start) begin
          baseNext     = loadBase;
          totalNext    = wordCount;
          wordIdxNext  = 16'd0;
          byteCntNext  = 2'd0;
          timerNext    = 32'd0;
          errorNext    = 1'b0;
          allBytesNext = (wordCount == 16'd0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          sumNext      = 32'd0;
          stateNext    = LOAD;
`else
          stateNext    = (wordCount == 16'd0) ? LAUNCH : LOAD;
`endif
        end
      end
      LOAD: begin
        if (accept) begin
          byteCntNext = byteCnt + 2'd1;
          shiftNext   = {shift[15:0], bus.byteIn};
          if (byteCnt == 2'd3) begin
            if (!allBytes) begin
              imemWrEnNext = 1'b1;
              imemAddrNext = startAddress + {14'd0, wordIdx, 2'b00};
              imemDataNext = word;
              wordIdxNext  = wordIdx + 16'd1;
              allBytesNext = ((wordIdx + 16'd1) == total);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
              sumNext      = sum + word;
`endif
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            else begin
              timerNext = 32'd0;
              if (word == sum) begin
                stateNext = LAUNCH;
              end else begin
                stateNext = DONE;
                errorNext = 1'b1;
              end
            end
`endif
          end
        end
`ifndef PROGRAM_LOADER_CHECKSUM_EN
        if (allBytes && bus.imemWrEn) begin
          stateNext = LAUNCH;
          timerNext = 32'd0;
        end
`endif
      end
      LAUNCH: begin
        if (timer == SETTLE_CYCLES - 1) begin
          stateNext = RUN;
          timerNext = 32'd0;
        end else begin
          timerNext = timer + 32'd1;
        end
      end
      RUN: begin
        if (endProgram) begin
          stateNext = DONE;
          errorNext = 1'b0;
        end else if (timer == RUN_TIMEOUT - 1) begin
          stateNext = DONE;
          errorNext = 1'b1;
        end else begin
          timerNext = timer + 32'd1;
        end
      end
      default: stateNext = IDLE;
    endcase

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    byteReadyNext = (stateNext == LOAD);
`else
    byteReadyNext = (stateNext == LOAD) && !allBytesNext;
`endif
    pcSelectNext = (stateNext != RUN);
    busyNext     = (stateNext == LOAD) || (stateNext == LAUNCH) || (stateNext == RUN);
    doneNext     = (stateNext == DONE);
  end

  // State and registered outputs; reset drops any partially assembled word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      total         <= 16'd0;
      wordIdx       <= 16'd0;
      byteCnt       <= 2'd0;
      shift         <= 24'd0;
      allBytes      <= 1'b0;
      timer         <= 32'd0;
      startAddress  <= 32'd0;
      bus.byteReady <= 1'b0;
      bus.imemWrEn  <= 1'b0;
      bus.imemAddr  <= 32'd0;
      bus.imemData  <= 32'd0;
      pcSelect      <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      sum           <= 32'd0;
`endif
    end else begin
      state         <= stateNext;
      total         <= totalNext;
      wordIdx       <= wordIdxNext;
      byteCnt       <= byteCntNext;
      shift         <= shiftNext;
      allBytes      <= allBytesNext;
      timer         <= timerNext;
      startAddress  <= baseNext;
      bus.byteReady <= byteReadyNext;
      bus.imemWrEn  <= imemWrEnNext;
      bus.imemAddr  <= imemAddrNext;
      bus.imemData  <= imemDataNext;
      pcSelect      <= pcSelectNext;
      busy          <= busyNext;
      done          <= doneNext;
      error         <= errorNext;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      sum           <= sumNext;
`endif
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed bench for program_loader. Expected memory writes are
// queued as bytes are delivered and checked by a write monitor for address, data
// and arrival cycle. Checksum scenarios run when PROGRAM_LOADER_CHECKSUM_EN is defined.
module tb_program_loader;
  localparam int unsigned RUN_TIMEOUT   = 10;
  localparam int unsigned SETTLE_CYCLES = 2;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam int LAUNCH_STEPS = SETTLE_CYCLES;
`else
  localparam int LAUNCH_STEPS = SETTLE_CYCLES + 1;
`endif

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] loadBase = 32'd0;
  logic [15:0] wordCount = 16'd0;
  logic        endProgram = 1'b0;
  logic        pcSelect, busy, done, error;
  logic [31:0] startAddress;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          writeCount = 0;
  exp_t        expQ[$];
  logic [31:0] prog[$];
  logic [31:0] progSum;

  program_loader_if bus();

  program_loader #(
    .RUN_TIMEOUT  (RUN_TIMEOUT),
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .loadBase    (loadBase),
    .wordCount   (wordCount),
    .bus         (bus),
    .pcSelect    (pcSelect),
    .startAddress(startAddress),
    .endProgram  (endProgram),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  // Free-running clock, 10 time units per cycle
  always #5 clk = ~clk;

  // Cycle counter used to time-stamp byte acceptance and memory writes
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Write monitor: every imemWrEn pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (bus.imemWrEn === 1'b1) begin
      exp_t e;
      writeCount++;
      checkOutput("write_expected", expQ.size(), (expQ.size() > 0) ? expQ.size() : 1);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("write_addr", bus.imemAddr, e.addr);
        checkOutput("write_data", bus.imemData, e.data);
        checkOutput("write_cycle", cyc, e.due);
      end
    end
  end

  // Watchdog so the run can never hang
  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_byteReady"}, {31'd0, bus.byteReady}, 32'd0);
    checkOutput({tag, "_imemWrEn"}, {31'd0, bus.imemWrEn}, 32'd0);
    checkOutput({tag, "_imemAddr"}, bus.imemAddr, 32'd0);
    checkOutput({tag, "_imemData"}, bus.imemData, 32'd0);
    checkOutput({tag, "_pcSelect"}, {31'd0, pcSelect}, 32'd1);
    checkOutput({tag, "_startAddress"}, startAddress, 32'd0);
    checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, "_done"}, {31'd0, done}, 32'd0);
    checkOutput({tag, "_error"}, {31'd0, error}, 32'd0);
  endtask

  // Drive one byte and hold it until the loader takes it (optionally after an idle cycle)
  task automatic applyStimulus(input logic [7:0] b, input bit stall);
    logic acc;
    int   guard;
    if (stall) begin
      bus.byteValid = 1'b0;
      step();
    end
    bus.byteIn    = b;
    bus.byteValid = 1'b1;
    guard = 0;
    acc   = 1'b0;
    while (!acc && guard < 20) begin
      acc = bus.byteReady;
      step();
      guard++;
    end
    if (!acc) checkOutput("byte_accept", {31'd0, acc}, 32'd1);
    bus.byteValid = 1'b0;
  endtask

  // Send every word of prog, queueing the write each completed word must produce
  task automatic sendProgram(input logic [31:0] base, input bit stall,
                             input logic [31:0] chkDelta);
    logic [31:0] s;
    logic [31:0] w;
    s = 32'd0;
    foreach (prog[i]) begin
      w = prog[i];
      for (int k = 0; k < 4; k++) applyStimulus(w[31-8*k -: 8], stall);
      expQ.push_back('{addr: base + 32'(i) * 32'd4, data: w, due: cyc});
      s = s + w;
    end
    s = s + chkDelta;
    progSum = s;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    for (int k = 0; k < 4; k++) applyStimulus(s[31-8*k -: 8], stall);
`endif
  endtask

  task automatic startLoad(input logic [31:0] base, input logic [15:0] count);
    start     = 1'b1;
    loadBase  = base;
    wordCount = count;
    step();
    start     = 1'b0;
    loadBase  = 32'hDEAD_BEEF;
    wordCount = 16'hFFFF;
  endtask

  task automatic waitPcLow(output int n);
    n = 0;
    while (pcSelect && n < 100) begin
      step();
      n++;
    end
  endtask

  task automatic finishRun(input string tag);
    endProgram = 1'b1;
    step();
    endProgram = 1'b0;
    checkOutput({tag, "_done"}, {31'd0, done}, 32'd1);
    checkOutput({tag, "_error"}, {31'd0, error}, 32'd0);
    checkOutput({tag, "_pcSelect"}, {31'd0, pcSelect}, 32'd1);
    checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int n;
    int wcBefore;
    bus.byteIn    = 8'd0;
    bus.byteValid = 1'b0;

    $display("[TB] reset values");
    step();
    step();
    checkResetValues("por");
    rst_n = 1'b1;
    step();

    $display("[TB] reset mid-load");
    startLoad(32'h0000_0200, 16'd2);
    checkOutput("load_byteReady", {31'd0, bus.byteReady}, 32'd1);
    checkOutput("load_busy", {31'd0, busy}, 32'd1);
    checkOutput("load_startAddress", startAddress, 32'h0000_0200);
    checkOutput("load_pcSelect", {31'd0, pcSelect}, 32'd1);
    prog = '{32'h1122_3344};
    sendProgram(32'h0000_0200, 1'b0, 32'd0);
    applyStimulus(8'h55, 1'b0);
    applyStimulus(8'h66, 1'b0);
    rst_n = 1'b0;
    #1;
    checkResetValues("midload_reset");
    step();
    step();
    checkOutput("midload_write_count", writeCount, 32'd1);
    checkOutput("midload_queue_empty", expQ.size(), 32'd0);
    rst_n = 1'b1;
    step();

    $display("[TB] basic load and run");
    startLoad(32'h0000_0100, 16'd2);
    prog = '{32'h1234_5678, 32'h9ABC_DEF0};
    sendProgram(32'h0000_0100, 1'b0, 32'd0);
    checkOutput("basic_pcSelect_held", {31'd0, pcSelect}, 32'd1);
    waitPcLow(n);
    checkOutput("basic_release_latency", n, LAUNCH_STEPS);
    checkOutput("basic_run_busy", {31'd0, busy}, 32'd1);
    repeat (5) step();
    checkOutput("basic_not_done_yet", {31'd0, done}, 32'd0);
    finishRun("basic");
    checkOutput("basic_write_count", writeCount, 32'd3);

    $display("[TB] stalled byte stream");
    startLoad(32'h0000_0100, 16'd2);
    sendProgram(32'h0000_0100, 1'b1, 32'd0);
    waitPcLow(n);
    checkOutput("stall_release_latency", n, LAUNCH_STEPS);
    step();
    finishRun("stall");
    checkOutput("stall_write_count", writeCount, 32'd5);

    $display("[TB] run timeout");
    startLoad(32'h0000_0300, 16'd1);
    prog = '{32'hAABB_CCDD};
    sendProgram(32'h0000_0300, 1'b0, 32'd0);
    waitPcLow(n);
    n = 0;
    while (!done && n < 100) begin
      step();
      n++;
    end
    checkOutput("timeout_cycles", n, RUN_TIMEOUT);
    checkOutput("timeout_error", {31'd0, error}, 32'd1);
    checkOutput("timeout_pcSelect", {31'd0, pcSelect}, 32'd1);

    $display("[TB] endProgram on the timeout cycle");
    startLoad(32'h0000_0300, 16'd1);
    checkOutput("restart_error_cleared", {31'd0, error}, 32'd0);
    checkOutput("restart_done_cleared", {31'd0, done}, 32'd0);
    sendProgram(32'h0000_0300, 1'b0, 32'd0);
    waitPcLow(n);
    repeat (RUN_TIMEOUT - 1) step();
    checkOutput("tie_not_done_yet", {31'd0, done}, 32'd0);
    finishRun("tie");

    $display("[TB] empty program and ignored start");
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    wcBefore = writeCount;
    startLoad(32'h0000_0400, 16'd0);
    checkOutput("empty_busy", {31'd0, busy}, 32'd1);
    checkOutput("empty_pcSelect", {31'd0, pcSelect}, 32'd1);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    checkOutput("empty_byteReady", {31'd0, bus.byteReady}, 32'd1);
    prog.delete();
    sendProgram(32'h0000_0400, 1'b0, 32'd0);
`else
    checkOutput("empty_byteReady", {31'd0, bus.byteReady}, 32'd0);
`endif
    waitPcLow(n);
    checkOutput("empty_release_latency", n, SETTLE_CYCLES);
    start     = 1'b1;
    loadBase  = 32'h0000_0999;
    wordCount = 16'd3;
    step();
    start     = 1'b0;
    checkOutput("ignored_start_busy", {31'd0, busy}, 32'd1);
    checkOutput("ignored_start_pcSelect", {31'd0, pcSelect}, 32'd0);
    checkOutput("ignored_start_byteReady", {31'd0, bus.byteReady}, 32'd0);
    checkOutput("ignored_start_startAddress", startAddress, 32'h0000_0400);
    step();
    finishRun("empty");
    checkOutput("empty_no_writes", writeCount, wcBefore);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    $display("[TB] checksum match");
    startLoad(32'h0000_0500, 16'd2);
    prog = '{32'd1, 32'd2};
    sendProgram(32'h0000_0500, 1'b0, 32'd0);
    checkOutput("chk_match_sum", progSum, 32'd3);
    waitPcLow(n);
    checkOutput("chk_match_release", n, LAUNCH_STEPS);
    finishRun("chk_match");

    $display("[TB] checksum mismatch");
    startLoad(32'h0000_0500, 16'd2);
    sendProgram(32'h0000_0500, 1'b0, 32'd1);
    checkOutput("chk_bad_done", {31'd0, done}, 32'd1);
    checkOutput("chk_bad_error", {31'd0, error}, 32'd1);
    checkOutput("chk_bad_busy", {31'd0, busy}, 32'd0);
    n = 0;
    repeat (20) begin
      if (!pcSelect) n++;
      step();
    end
    checkOutput("chk_bad_pc_never_low", n, 32'd0);
`endif

    step();
    step();
    checkOutput("final_queue_empty", expQ.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
